// File: rtl/csr_access_seq.sv
// Multi-cycle sequencer that issues CSR read / read-modify-write and trap strobes
// for one SYSTEM instruction at a time and returns the result via valid/ready.
module csr_access_seq #(
    parameter bit SUPPRESS_X0_SET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    output logic [2:0]  csr_ctr,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wd,
    output logic [31:0] csr_pc,
    input  logic [31:0] csr_rd,
    input  logic [31:0] csr_pc_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        illegal
);

    typedef enum logic [2:0] {StIdle, StRead, StWrite, StTrap, StResp} state_e;
    typedef enum logic [2:0] {OpCsrrw, OpCsrrs, OpEcall, OpMret, OpIllegal} op_e;

    function automatic logic csr_supported(input logic [11:0] a);
        logic ok;
        ok = 1'b0;
        case (a)
            12'h300, 12'h305, 12'h341, 12'h342: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic op_e decode(input logic [31:0] w);
        op_e op;
        op = OpIllegal;
        if (w[6:0] == 7'b1110011) begin
            case (w[14:12])
                3'b001: op = OpCsrrw;
                3'b010: op = OpCsrrs;
                3'b000: begin
                    if (w[31:20] == 12'h000) begin
                        op = OpEcall;
                    end else if (w[31:20] == 12'h302) begin
                        op = OpMret;
                    end
                end
                default: op = OpIllegal;
            endcase
            // Unknown CSRs are rejected before any strobe is issued.
            if ((op == OpCsrrw || op == OpCsrrs) && !csr_supported(w[31:20])) begin
                op = OpIllegal;
            end
        end
        return op;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] inst_q, pc_q, rs1_q, old_q, redir_pc_q;
    op_e         op_in, op_lat;

    assign op_in  = decode(inst);
    assign op_lat = decode(inst_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q     <= '0;
            pc_q       <= '0;
            rs1_q      <= '0;
            old_q      <= '0;
            redir_pc_q <= '0;
        end else begin
            if (state_q == StIdle && in_valid) begin
                inst_q <= inst;
                pc_q   <= pc;
                rs1_q  <= rs1_data;
            end
            if (state_q == StRead) begin
                old_q <= csr_rd;
            end
            if (state_q == StTrap) begin
                redir_pc_q <= csr_pc_out;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    case (op_in)
                        OpCsrrw, OpCsrrs: state_d = StRead;
                        OpEcall, OpMret:  state_d = StTrap;
                        default:          state_d = StResp;
                    endcase
                end
            end
            StRead:  state_d = StWrite;
            StWrite: state_d = StResp;
            StTrap:  state_d = StResp;
            StResp: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        csr_ctr     = 3'b000;
        csr_addr    = '0;
        csr_wd      = '0;
        csr_pc      = '0;
        out_valid   = 1'b0;
        rd_we       = 1'b0;
        rd_addr     = '0;
        rd_wdata    = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        illegal     = 1'b0;
        unique case (state_q)
            StIdle: in_ready = 1'b1;
            StRead: csr_addr = inst_q[31:20];
            StWrite: begin
                csr_addr = inst_q[31:20];
                csr_wd   = rs1_q;
                if (op_lat == OpCsrrw) begin
                    csr_ctr = 3'b100;
                end else if (!(SUPPRESS_X0_SET && inst_q[19:15] == 5'd0)) begin
                    csr_ctr = 3'b110;
                end
            end
            StTrap: begin
                if (op_lat == OpEcall) begin
                    csr_ctr = 3'b010;
                    csr_pc  = pc_q;
                end else begin
                    csr_ctr = 3'b011;
                end
            end
            StResp: begin
                out_valid = 1'b1;
                rd_addr   = inst_q[11:7];
                case (op_lat)
                    OpCsrrw, OpCsrrs: begin
                        rd_we    = (inst_q[11:7] != 5'd0);
                        rd_wdata = old_q;
                    end
                    OpEcall, OpMret: begin
                        redirect    = 1'b1;
                        redirect_pc = redir_pc_q;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: in_ready = 1'b0;
        endcase
    end

endmodule
